// File: rtl/spi_data_pkg.sv
// rtl/spi_data_pkg.sv - shared widths, frame length and state encoding for the SPI responder
package spi_data_pkg;

    localparam int WORD_BITS      = 16;
    localparam int SIN_INDEX_BITS = 12;
    localparam int UART_ID_BITS   = 4;

    // One frame is exactly two bytes; the counter must be able to hold the value 16.
    localparam int FRAME_BITS = 16;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

    localparam logic [BIT_CNT_W-1:0] FRAME_CNT    = BIT_CNT_W'(FRAME_BITS);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_IDX = BIT_CNT_W'(FRAME_BITS - 1);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_HOLD  = 2'd2;

endpackage

// File: rtl/spi_input_sync.sv
// rtl/spi_input_sync.sv - synchronisers and edge detectors for the SPI pins
//
// Ports:
//   clk, reset_l              system clock, async active-low reset
//   spi_clk, cs_n, mosi       raw SPI pins
//   sclk_s, cs_n_s, mosi_s    synchronised levels
//   sclk_rise, sclk_fall      one-clk pulses on synced SCLK edges
//   cs_fall, cs_rise          one-clk pulses on synced CS_n edges
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic spi_clk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_s,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    // Marks which pipeline stages hold real pin samples rather than reset
    // values. Edges are only reported once both the current and previous
    // synced values are real, so a CS already low at reset release does not
    // look like a falling edge.
    logic [SYNC_STAGES:0]   live_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            live_q      <= '0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_clk};
            cs_q        <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_q[SYNC_STAGES-1];
            live_q      <= {live_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic edge_en;

    assign edge_en   = live_q[SYNC_STAGES];
    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = edge_en &  sclk_s & ~sclk_prev_q;
    assign sclk_fall = edge_en & ~sclk_s &  sclk_prev_q;
    assign cs_fall   = edge_en & ~cs_n_s &  cs_prev_q;
    assign cs_rise   = edge_en &  cs_n_s & ~cs_prev_q;

endmodule

// File: rtl/spi_sin_index_responder.sv
// rtl/spi_sin_index_responder.sv - SPI mode-0 slave serving {sin_index, uart_id} words
//
// Ports:
//   clk, reset_l                       system clock, async active-low reset
//   spi_clk, cs_n, mosi, miso, miso_oe SPI pins (mode 0, MSB first, 16-bit frames)
//   load_valid/load_ready              one-deep word buffer handshake
//   load_sin_index, load_uart_id       word bits [15:4] and [3:0]
//   frame_done, frame_abort, underrun  one-clk status pulses
//   rx_word                            MOSI bits of the last completed frame
module spi_sin_index_responder
    import spi_data_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter bit REPEAT_ON_UNDERRUN = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic                      spi_clk,
    input  logic                      cs_n,
    input  logic                      mosi,
    output logic                      miso,
    output logic                      miso_oe,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [SIN_INDEX_BITS-1:0] load_sin_index,
    input  logic [UART_ID_BITS-1:0]   load_uart_id,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic                      underrun,
    output logic [WORD_BITS-1:0]      rx_word
);

    logic sclk_s, cs_n_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_input_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .reset_l   (reset_l),
        .spi_clk   (spi_clk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_s    (sclk_s),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    // Only the edge pulses drive the FSM; the synced levels are not needed here.
    logic unused_levels;
    assign unused_levels = sclk_s ^ cs_n_s;

    state_t                 state_q, state_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [WORD_BITS-1:0]   last_q, last_d;
    logic [WORD_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [WORD_BITS-1:0]   rx_word_q, rx_word_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   buf_q, buf_d;
    logic                   buf_valid_q, buf_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_abort_q, frame_abort_d;
    logic                   underrun_q, underrun_d;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            last_q        <= '0;
            rx_shift_q    <= '0;
            rx_word_q     <= '0;
            bit_cnt_q     <= '0;
            buf_q         <= '0;
            buf_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_abort_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            last_q        <= last_d;
            rx_shift_q    <= rx_shift_d;
            rx_word_q     <= rx_word_d;
            bit_cnt_q     <= bit_cnt_d;
            buf_q         <= buf_d;
            buf_valid_q   <= buf_valid_d;
            frame_done_q  <= frame_done_d;
            frame_abort_q <= frame_abort_d;
            underrun_q    <= underrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        last_d        = last_q;
        rx_shift_d    = rx_shift_q;
        rx_word_d     = rx_word_q;
        bit_cnt_d     = bit_cnt_q;
        buf_d         = buf_q;
        buf_valid_d   = buf_valid_q;
        frame_done_d  = 1'b0;
        frame_abort_d = 1'b0;
        underrun_d    = 1'b0;

        // A load can only be accepted while the buffer is empty, so it never
        // collides with the frame-start consume below.
        if (load_valid && !buf_valid_q) begin
            buf_d       = {load_sin_index, load_uart_id};
            buf_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    if (buf_valid_q) begin
                        shift_d     = buf_q;
                        last_d      = buf_q;
                        buf_valid_d = 1'b0;
                    end else begin
                        shift_d    = REPEAT_ON_UNDERRUN ? last_q : '0;
                        underrun_d = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (cs_rise) begin
                    // Short frame: the consumed buffer word is lost on purpose.
                    state_d       = ST_IDLE;
                    frame_abort_d = 1'b1;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[WORD_BITS-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT_IDX) begin
                            state_d = ST_HOLD;
                        end
                    end
                    if (sclk_fall && (bit_cnt_q != FRAME_CNT)) begin
                        shift_d = shift_q << 1;
                    end
                end
            end

            ST_HOLD: begin
                if (cs_rise) begin
                    state_d      = ST_IDLE;
                    rx_word_d    = rx_shift_q;
                    frame_done_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign miso        = (state_q == ST_SHIFT) & shift_q[WORD_BITS-1];
    assign miso_oe     = (state_q != ST_IDLE);
    assign load_ready  = ~buf_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_abort = frame_abort_q;
    assign underrun    = underrun_q;
    assign rx_word     = rx_word_q;

endmodule

// File: tb/tb_spi_sin_index_responder.sv
// tb/tb_spi_sin_index_responder.sv - randomized self-checking bench for spi_sin_index_responder
module tb_spi_sin_index_responder;

    localparam int HALF  = 6;
    localparam int SETUP = 8;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        spi_clk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        load_valid = 1'b0;
    logic [11:0] load_sin_index = '0;
    logic [3:0]  load_uart_id = '0;

    logic        miso, miso_oe, load_ready, frame_done, frame_abort, underrun;
    logic [15:0] rx_word;
    logic        miso0, miso_oe0, load_ready0, frame_done0, frame_abort0, underrun0;
    logic [15:0] rx_word0;

    spi_sin_index_responder #(.SYNC_STAGES(2), .REPEAT_ON_UNDERRUN(1'b1)) dut (
        .clk(clk), .reset_l(reset_l), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .load_valid(load_valid), .load_ready(load_ready),
        .load_sin_index(load_sin_index), .load_uart_id(load_uart_id),
        .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun),
        .rx_word(rx_word)
    );

    spi_sin_index_responder #(.SYNC_STAGES(2), .REPEAT_ON_UNDERRUN(1'b0)) dut0 (
        .clk(clk), .reset_l(reset_l), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso0), .miso_oe(miso_oe0), .load_valid(load_valid), .load_ready(load_ready0),
        .load_sin_index(load_sin_index), .load_uart_id(load_uart_id),
        .frame_done(frame_done0), .frame_abort(frame_abort0), .underrun(underrun0),
        .rx_word(rx_word0)
    );

    always #5 clk = ~clk;

    int done_cnt = 0, abort_cnt = 0, under_cnt = 0, under0_cnt = 0, done0_cnt = 0;

    always @(negedge clk) begin
        if (frame_done)  done_cnt   <= done_cnt + 1;
        if (frame_abort) abort_cnt  <= abort_cnt + 1;
        if (underrun)    under_cnt  <= under_cnt + 1;
        if (underrun0)   under0_cnt <= under0_cnt + 1;
        if (frame_done0) done0_cnt  <= done0_cnt + 1;
    end

    // Reference model: buffer contents, last word sent, last completed rx word.
    bit          m_buf_v = 1'b0;
    logic [15:0] m_buf = '0;
    logic [15:0] m_last = '0;
    logic [15:0] m_rx = '0;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_buf_v = 1'b0;
        m_buf   = '0;
        m_last  = '0;
        m_rx    = '0;
    endtask

    task automatic load_word(input logic [15:0] w);
        @(negedge clk);
        check("load_ready_empty", {31'd0, load_ready}, 32'd1);
        load_valid     = 1'b1;
        load_sin_index = w[15:4];
        load_uart_id   = w[3:0];
        @(negedge clk);
        load_valid = 1'b0;
        m_buf_v = 1'b1;
        m_buf   = w;
        check("load_ready_full", {31'd0, load_ready}, 32'd0);
    endtask

    task automatic run_frame(input int nbits, input logic [31:0] mbits, input bit active,
                             input bit hold_load, input logic [15:0] hold_word);
        int d0, a0, u0, u00, dd0;
        logic [31:0] rd, rd0, ew, ew0, exp_rd, exp_rd0;
        bit exp_under;
        d0 = done_cnt; a0 = abort_cnt; u0 = under_cnt; u00 = under0_cnt; dd0 = done0_cnt;
        rd = '0; rd0 = '0;
        exp_under = 1'b0;
        ew = '0; ew0 = '0;
        if (active) begin
            if (m_buf_v) begin
                ew = {16'h0, m_buf}; ew0 = {16'h0, m_buf};
                m_last = m_buf; m_buf_v = 1'b0;
            end else begin
                ew = {16'h0, m_last}; ew0 = '0;
                exp_under = 1'b1;
            end
        end
        cs_n = 1'b0;
        wclk(SETUP);
        check("miso_oe_selected", {31'd0, miso_oe}, {31'd0, active});
        check("load_ready_at_start", {31'd0, load_ready}, {31'd0, !m_buf_v});
        for (int i = 0; i < nbits; i++) begin
            mosi = mbits[nbits-1-i];
            wclk(HALF);
            spi_clk = 1'b1;
            #1;
            rd  = {rd[30:0], miso};
            rd0 = {rd0[30:0], miso0};
            wclk(HALF);
            spi_clk = 1'b0;
        end
        wclk(HALF);
        if (hold_load && active && nbits >= 16) begin
            check("miso_zero_in_hold", {31'd0, miso}, 32'd0);
            load_word(hold_word);
        end
        cs_n = 1'b1;
        wclk(SETUP);
        exp_rd  = (nbits <= 16) ? (ew >> (16 - nbits)) : (ew << (nbits - 16));
        exp_rd0 = (nbits <= 16) ? (ew0 >> (16 - nbits)) : (ew0 << (nbits - 16));
        if (active && nbits >= 16) m_rx = 16'(mbits >> (nbits - 16));
        check("miso_bits", rd, exp_rd);
        check("miso_bits_norepeat", rd0, exp_rd0);
        check("underrun_pulses", under_cnt - u0, {31'd0, exp_under});
        check("underrun_pulses_norepeat", under0_cnt - u00, {31'd0, exp_under});
        check("frame_done_pulses", done_cnt - d0, (active && nbits >= 16) ? 1 : 0);
        check("frame_done_pulses_norepeat", done0_cnt - dd0, (active && nbits >= 16) ? 1 : 0);
        check("frame_abort_pulses", abort_cnt - a0, (active && nbits < 16) ? 1 : 0);
        check("rx_word", {16'h0, rx_word}, {16'h0, m_rx});
        check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
    endtask

    initial begin
        logic [31:0] rb;
        logic        oe_seen;
        int          nb, sel;

        model_reset();
        wclk(3);
        check("reset_miso", {31'd0, miso}, 32'd0);
        check("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("reset_load_ready", {31'd0, load_ready}, 32'd1);
        check("reset_rx_word", {16'h0, rx_word}, 32'd0);
        check("reset_pulses", {29'd0, frame_done, frame_abort, underrun}, 32'd0);
        reset_l = 1'b1;
        wclk(4);

        // Basic word, MOSI 0x2121.
        load_word(16'hABC5);
        run_frame(16, 32'h2121, 1'b1, 1'b0, 16'h0);

        // Underrun: resend ABC5 (repeat) / 0000 (no repeat).
        run_frame(16, 32'h5A3C, 1'b1, 1'b0, 16'h0);

        // Abort after 5 bits, then underrun resends 1234.
        load_word(16'h1234);
        run_frame(5, 32'h15, 1'b1, 1'b0, 16'h0);
        run_frame(16, 32'hFFFF, 1'b1, 1'b0, 16'h0);

        // Back-to-back with a load during HOLD, then a full buffer ignores new offers.
        load_word(16'h0FF1);
        run_frame(16, 32'h8421, 1'b1, 1'b1, 16'hF00E);
        @(negedge clk);
        load_valid = 1'b1;
        load_sin_index = 12'h111;
        load_uart_id = 4'h1;
        wclk(5);
        check("load_ready_full_held", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
        run_frame(16, 32'h0001, 1'b1, 1'b0, 16'h0);

        // Overlong frame: 20 SCLK cycles.
        load_word(16'h8001);
        run_frame(20, 32'hABCDE, 1'b1, 1'b0, 16'h0);

        // Reset in the middle of a frame, released with CS still low.
        load_word(16'hC3A5);
        cs_n = 1'b0;
        wclk(SETUP);
        for (int i = 0; i < 9; i++) begin
            wclk(HALF); spi_clk = 1'b1; wclk(HALF); spi_clk = 1'b0;
        end
        reset_l = 1'b0;
        #1;
        check("midreset_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("midreset_miso", {31'd0, miso}, 32'd0);
        model_reset();
        wclk(3);
        reset_l = 1'b1;
        oe_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wclk(HALF); spi_clk = 1'b1; #1; oe_seen |= miso_oe;
            wclk(HALF); spi_clk = 1'b0; #1; oe_seen |= miso_oe;
        end
        check("no_frame_after_reset", {31'd0, oe_seen}, 32'd0);
        wclk(HALF);
        cs_n = 1'b1;
        wclk(SETUP);
        check("postreset_rx_word", {16'h0, rx_word}, 32'd0);
        check("postreset_load_ready", {31'd0, load_ready}, 32'd1);
        run_frame(16, 32'h7E7E, 1'b1, 1'b0, 16'h0);

        // Randomized frames.
        for (int k = 0; k < 12; k++) begin
            if (!m_buf_v && ($urandom_range(0, 2) != 0)) load_word(16'($urandom));
            sel = int'($urandom_range(0, 5));
            if (sel == 0)      nb = int'($urandom_range(1, 15));
            else if (sel == 5) nb = int'($urandom_range(17, 20));
            else               nb = 16;
            rb = $urandom;
            run_frame(nb, rb, 1'b1, ($urandom_range(0, 1) == 1) && !m_buf_v, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_sin_index_responder.md
Name: spi_sin_index_responder

Overview:
- SPI slave (responder) that serves the 16-bit {sin_index, uart_id} word to the FPGA-side SPI requester.
- Sits on the controller board between the waveform/scheduler logic, which supplies words, and the SPI pins driven by the requesting master.
- Each frame is one CS-low window of 16 SCLK cycles (two bytes), SPI mode 0, MSB first.
- Captures the master's MOSI bytes for diagnostics.

Parameters:
- SYNC_STAGES, 2: flops in the SCLK/CS_n/MOSI synchronisers (min 2).
- REPEAT_ON_UNDERRUN, 1: 1 = resend the last transmitted word when no new word is queued; 0 = send 16'h0000.

Ports:
- clk, in, 1: system clock; must be at least 2*(SYNC_STAGES+2) times the SCLK frequency.
- reset_l, in, 1: asynchronous, active-low reset.
- spi_clk, in, 1: SPI clock from the master; idles low.
- cs_n, in, 1: chip select, active low.
- mosi, in, 1: master data in.
- miso, out, 1: slave data out.
- miso_oe, out, 1: output enable for the MISO pad; 1 while selected.
- load_valid, in, 1: new word offered.
- load_ready, out, 1: buffer empty; word accepted when valid && ready.
- load_sin_index, in, 12: word bits [15:4].
- load_uart_id, in, 4: word bits [3:0].
- frame_done, out, 1: one-clk pulse when 16 bits complete and CS rises.
- frame_abort, out, 1: one-clk pulse when CS rises after 1 to 15 bits.
- underrun, out, 1: one-clk pulse at frame start if the buffer is empty.
- rx_word, out, 16: MOSI bits of the last completed frame; first received bit in bit 15.

Behaviour:
- Reset (async assert, sync release): miso=0, miso_oe=0, load_ready=1, buffer empty, shift register = 0, last-word register = 0, rx_word=0, all pulses=0, state=IDLE.
- Synchroniser reset values: cs_n=1, spi_clk=0, so a frame already in progress when reset is released is ignored until CS goes high and then low again.
- Input path: all SPI inputs pass through SYNC_STAGES flops, then edge detection in the clk domain.
- Buffer handshake: one-deep holding register.
  - load_ready = ~buf_valid.
  - Accept sets buf_valid the next clk.
  - There is no bypass into the shift register.
- State machine:
  - IDLE: miso_oe=0. On a synced CS falling edge, go to SHIFT.
    - If buf_valid: shift_reg <= buffer, last_word <= buffer, buf_valid <= 0.
    - Else: shift_reg <= (REPEAT_ON_UNDERRUN ? last_word : 0) and pulse underrun.
    - If a load is accepted in the same clk, it goes into the buffer and the current frame still underruns.
  - SHIFT: miso_oe=1, miso = shift_reg[15], valid within SYNC_STAGES+1 clk of CS falling.
    - Synced SCLK rising: sample mosi into the rx shift register and increment bit_cnt (5 bits).
    - Synced SCLK falling: shift_reg <= shift_reg << 1, unless bit_cnt=16.
    - When bit_cnt reaches 16, go to HOLD.
  - HOLD: miso=0. Extra SCLK edges are ignored.
    - On synced CS rising: rx_word <= rx shift, pulse frame_done, go to IDLE.
  - CS rising while in SHIFT: pulse frame_abort, leave rx_word unchanged, go to IDLE.
    - The consumed buffer word is not restored.
  - CS falling and CS rising are never both seen in the same clk; SYNC_STAGES sampling guarantees this.
- Timing: the master must hold CS low for at least SYNC_STAGES+2 clk before the first SCLK rising edge, and each SCLK half-period must be at least SYNC_STAGES+2 clk.
- Byte order on the wire: sin_index[11:4], then {sin_index[3:0], uart_id}.

Decomposition:
- Package spi_data_pkg:
  - WORD_BITS=16, SIN_INDEX_BITS=12, UART_ID_BITS=4.
  - Frame bit count 16 and the bit_cnt width.
  - State encoding IDLE/SHIFT/HOLD as 2-bit localparams.
- Sub-module spi_input_sync: SYNC_STAGES-deep synchronisers for spi_clk, cs_n and mosi; outputs the synced levels plus sclk_rise, sclk_fall, cs_fall and cs_rise one-clk pulses. Reset values as specified in Behaviour.

Test Plan:
1. Load sin_index=12'hABC, uart_id=4'h5, then run a 16-bit mode-0 frame with MOSI bytes 0x21,0x21 -> master receives 0xAB then 0xC5; frame_done pulses once; rx_word=16'h2121; load_ready returns to 1 at frame start.
2. No load before the frame, REPEAT_ON_UNDERRUN=1, previous word 16'hABC5 -> underrun pulses one clk after CS falls; master reads 0xABC5 again. Repeat with REPEAT_ON_UNDERRUN=0 -> master reads 0x0000.
3. Load 16'h1234, then CS low for 5 SCLK cycles and release -> frame_abort pulses, no frame_done, rx_word unchanged. Next frame with no load underruns and resends 16'h1234.
4. Back-to-back: load 16'h0FF1, frame, load 16'hF00E during HOLD, second frame -> reads 0x0FF1 then 0xF00E, no underrun. load_valid held high with a full buffer keeps load_ready=0 and the buffer unchanged.
5. Assert reset_l low at bit 9 of a frame, release while CS is still low -> miso_oe=0 and miso=0 immediately; no shifting until CS goes high then low; the next frame reads 0x0000 and underrun pulses.
6. Run 20 SCLK cycles in one CS window with word 16'h8001 -> first 16 bits are 0x8001, bits 17-20 are 0, frame_done pulses once.
